// File: rtl/text_term_if.sv
// Event inputs and character-buffer/cursor outputs of the terminal controller.
// The master modport is the controller side; slave is the decoder/buffer side.
interface text_term_if #(
  parameter int CHAR_HORZ_W = 7,
  parameter int CHAR_VERT_W = 5
);
  logic                   ascii_vld;
  logic [7:0]             ascii;
  logic                   scancode_vld;
  logic [7:0]             scancode;
  logic                   char_write_en;
  logic [CHAR_HORZ_W-1:0] char_hpos;
  logic [CHAR_VERT_W-1:0] char_vpos;
  logic [7:0]             char_symbol;
  logic [CHAR_HORZ_W-1:0] cursor_hpos;
  logic [CHAR_VERT_W-1:0] cursor_vpos;
  logic                   cursor_valid;
  logic                   busy;

  modport master (
    input  ascii_vld, ascii, scancode_vld, scancode,
    output char_write_en, char_hpos, char_vpos, char_symbol,
    output cursor_hpos, cursor_vpos, cursor_valid, busy
  );

  modport slave (
    output ascii_vld, ascii, scancode_vld, scancode,
    input  char_write_en, char_hpos, char_vpos, char_symbol,
    input  cursor_hpos, cursor_vpos, cursor_valid, busy
  );
endinterface

// File: rtl/text_term_ctrl.sv
// Terminal controller: turns keyboard events into character-buffer writes and
// cursor moves, with a full-screen clear sweep after reset and on Ctrl-L.
module text_term_ctrl #(
  parameter int CHAR_HORZ_CNT = 80,
  parameter int CHAR_VERT_CNT = 25,
  parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
  parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT)
) (
  input  logic       clk,
  input  logic       rst_n,
  text_term_if.master term
);

  typedef enum logic {CLEAR, IDLE} state_e;

  localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
  localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
  localparam logic [7:0]             SPACE  = 8'h20;

  state_e                 state, state_nxt;
  logic [CHAR_HORZ_W-1:0] clr_h_p1, clr_h_p0, cur_h_p1, cur_h_p0, wr_h_p1, wr_h_p0;
  logic [CHAR_VERT_W-1:0] clr_v_p1, clr_v_p0, cur_v_p1, cur_v_p0, wr_v_p1, wr_v_p0;
  logic                   clr_done_p1, clr_done_p0, wr_en_p1, wr_en_p0;
  logic [7:0]             wr_sym_p1, wr_sym_p0;

  // Wrapping steps compare against the last index so non-power-of-two sizes work.
  function automatic logic [CHAR_HORZ_W-1:0] h_inc(input logic [CHAR_HORZ_W-1:0] h);
    return (h == H_LAST) ? '0 : h + CHAR_HORZ_W'(1);
  endfunction

  function automatic logic [CHAR_HORZ_W-1:0] h_dec(input logic [CHAR_HORZ_W-1:0] h);
    return (h == '0) ? H_LAST : h - CHAR_HORZ_W'(1);
  endfunction

  function automatic logic [CHAR_VERT_W-1:0] v_inc(input logic [CHAR_VERT_W-1:0] v);
    return (v == V_LAST) ? '0 : v + CHAR_VERT_W'(1);
  endfunction

  function automatic logic [CHAR_VERT_W-1:0] v_dec(input logic [CHAR_VERT_W-1:0] v);
    return (v == '0) ? V_LAST : v - CHAR_VERT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      clr_h_p1    <= '0;
      clr_v_p1    <= '0;
      clr_done_p1 <= 1'b0;
      cur_h_p1    <= '0;
      cur_v_p1    <= '0;
      wr_en_p1    <= 1'b0;
      wr_h_p1     <= '0;
      wr_v_p1     <= '0;
      wr_sym_p1   <= SPACE;
    end else begin
      state       <= state_nxt;
      clr_h_p1    <= clr_h_p0;
      clr_v_p1    <= clr_v_p0;
      clr_done_p1 <= clr_done_p0;
      cur_h_p1    <= cur_h_p0;
      cur_v_p1    <= cur_v_p0;
      wr_en_p1    <= wr_en_p0;
      wr_h_p1     <= wr_h_p0;
      wr_v_p1     <= wr_v_p0;
      wr_sym_p1   <= wr_sym_p0;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_h_p0    = clr_h_p1;
    clr_v_p0    = clr_v_p1;
    clr_done_p0 = clr_done_p1;
    cur_h_p0    = cur_h_p1;
    cur_v_p0    = cur_v_p1;
    wr_en_p0    = 1'b0;
    wr_h_p0     = wr_h_p1;
    wr_v_p0     = wr_v_p1;
    wr_sym_p0   = wr_sym_p1;
    unique case (state)
      CLEAR: begin
        // The done flag holds CLEAR for one extra cycle so busy covers the last write.
        if (clr_done_p1) begin
          state_nxt   = IDLE;
          clr_done_p0 = 1'b0;
          cur_h_p0    = '0;
          cur_v_p0    = '0;
        end else begin
          wr_en_p0  = 1'b1;
          wr_h_p0   = clr_h_p1;
          wr_v_p0   = clr_v_p1;
          wr_sym_p0 = SPACE;
          clr_h_p0  = h_inc(clr_h_p1);
          if (clr_h_p1 == H_LAST) begin
            clr_v_p0    = v_inc(clr_v_p1);
            clr_done_p0 = (clr_v_p1 == V_LAST);
          end
        end
      end
      IDLE: begin
        if (term.ascii_vld) begin
          if (term.ascii >= 8'h20 && term.ascii <= 8'h7E) begin
            wr_en_p0  = 1'b1;
            wr_h_p0   = cur_h_p1;
            wr_v_p0   = cur_v_p1;
            wr_sym_p0 = term.ascii;
            cur_h_p0  = h_inc(cur_h_p1);
            if (cur_h_p1 == H_LAST) cur_v_p0 = v_inc(cur_v_p1);
          end else begin
            case (term.ascii)
              8'h0D: begin
                cur_h_p0 = '0;
                cur_v_p0 = v_inc(cur_v_p1);
              end
              8'h08: begin
                if (cur_h_p1 != '0 || cur_v_p1 != '0) begin
                  cur_h_p0  = h_dec(cur_h_p1);
                  cur_v_p0  = (cur_h_p1 == '0) ? v_dec(cur_v_p1) : cur_v_p1;
                  wr_en_p0  = 1'b1;
                  wr_h_p0   = h_dec(cur_h_p1);
                  wr_v_p0   = (cur_h_p1 == '0) ? v_dec(cur_v_p1) : cur_v_p1;
                  wr_sym_p0 = SPACE;
                end
              end
              8'h0C: begin
                // Cell (0,0) is written right away; the sweep resumes at the next cell.
                state_nxt   = CLEAR;
                wr_en_p0    = 1'b1;
                wr_h_p0     = '0;
                wr_v_p0     = '0;
                wr_sym_p0   = SPACE;
                cur_h_p0    = '0;
                cur_v_p0    = '0;
                clr_h_p0    = h_inc('0);
                clr_v_p0    = (H_LAST == '0) ? v_inc('0) : '0;
                clr_done_p0 = (H_LAST == '0) && (V_LAST == '0);
              end
              default: ;
            endcase
          end
        end else if (term.scancode_vld) begin
          case (term.scancode)
            8'h6B:   cur_h_p0 = h_dec(cur_h_p1);
            8'h74:   cur_h_p0 = h_inc(cur_h_p1);
            8'h75:   cur_v_p0 = v_dec(cur_v_p1);
            8'h72:   cur_v_p0 = v_inc(cur_v_p1);
            default: ;
          endcase
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign term.char_write_en = wr_en_p1;
  assign term.char_hpos     = wr_h_p1;
  assign term.char_vpos     = wr_v_p1;
  assign term.char_symbol   = wr_sym_p1;
  assign term.cursor_hpos   = cur_h_p1;
  assign term.cursor_vpos   = cur_v_p1;
  assign term.cursor_valid  = (state == IDLE);
  assign term.busy          = (state == CLEAR);

endmodule
